// File: rtl/lamp_shift_out.sv
// Serialises the lamp vector into a 74HC595-style chain: shift clock, data, latch.
// A frame starts when lp differs from the last latched frame, on force_upd, or on a pending refresh.
module lamp_shift_out #(
  parameter int unsigned MX_LP     = 16,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned FF_DLY    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MX_LP-1:0] lp,
  input  logic             force_upd,
  output logic             sr_clk,
  output logic             sr_dat,
  output logic             sr_lat,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BW = (MX_LP > 1) ? $clog2(MX_LP) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // FF_DLY only exists for instantiation compatibility; flops carry no delay.
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1 + FF_DLY * 0);
  localparam logic [BW-1:0] BIT_TOP  = BW'(MX_LP - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SH_LO = 2'd1;
  localparam logic [1:0] SH_HI = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  logic [1:0]       state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [MX_LP-1:0] shadow;
  logic [MX_LP-1:0] sent_lp;
  logic             pend;
  logic             start;

  function automatic logic pick(input logic [MX_LP-1:0] v, input logic [BW-1:0] cnt);
    if (MSB_FIRST) return v[cnt];
    else           return v[BIT_TOP - cnt];
  endfunction

  always_comb begin
    start = (lp != sent_lp) || force_upd || pend;
  end

  // Outputs are loaded on the transition into each state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shadow     <= '0;
      sent_lp    <= '0;
      pend       <= 1'b0;
      sr_clk     <= 1'b0;
      sr_dat     <= 1'b0;
      sr_lat     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (force_upd && (state != IDLE)) pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            shadow  <= lp;
            bit_cnt <= BIT_TOP;
            pend    <= 1'b0;
            div_cnt <= '0;
            state   <= SH_LO;
            busy    <= 1'b1;
            sr_clk  <= 1'b0;
            sr_dat  <= pick(lp, BIT_TOP);
          end
        end
        SH_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= SH_HI;
            sr_clk  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SH_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sr_clk  <= 1'b0;
            if (bit_cnt == '0) begin
              state  <= LATCH;
              sr_dat <= 1'b0;
              sr_lat <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              state   <= SH_LO;
              sr_dat  <= pick(shadow, bit_cnt - 1'b1);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            state      <= IDLE;
            sr_lat     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            sent_lp    <= shadow;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_shift_out.sv
// Bench for lamp_shift_out: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a frame-position model, plus literal frame expectations.
module tb_lamp_shift_out;

  localparam int N  = 16;
  localparam int D  = 2;
  localparam int FL = 2 * D * N + D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        force_upd = 1'b0;
  logic [15:0] lp = '0;
  logic        m_clk, m_dat, m_lat, m_busy, m_done;
  logic        l_clk, l_dat, l_lat, l_busy, l_done;

  lamp_shift_out #(.MX_LP(16), .CLK_DIV(2), .MSB_FIRST(1'b1), .FF_DLY(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .lp(lp), .force_upd(force_upd),
    .sr_clk(m_clk), .sr_dat(m_dat), .sr_lat(m_lat), .busy(m_busy), .frame_done(m_done)
  );

  lamp_shift_out #(.MX_LP(16), .CLK_DIV(2), .MSB_FIRST(1'b0), .FF_DLY(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .lp(lp), .force_upd(force_upd),
    .sr_clk(l_clk), .sr_dat(l_dat), .sr_lat(l_lat), .busy(l_busy), .frame_done(l_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is a position counter 0..FL-1 over a captured word.
  bit          m_act = 1'b0, m_pnd = 1'b0, m_dn = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_frm = '0, m_snt = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_act = 1'b0; m_pnd = 1'b0; m_dn = 1'b0; m_pos = 0; m_frm = '0; m_snt = '0;
    end else if (m_act) begin
      if (force_upd) m_pnd = 1'b1;
      m_pos = m_pos + 1;
      if (m_pos == FL) begin
        m_act = 1'b0; m_snt = m_frm; m_dn = 1'b1;
      end
    end else begin
      m_dn = 1'b0;
      if ((lp != m_snt) || force_upd || m_pnd) begin
        m_act = 1'b1; m_pos = 0; m_frm = lp; m_pnd = 1'b0;
      end
    end
  end

  function automatic logic [4:0] expect_out(input bit msb);
    bit shifting, hi, dat;
    int k, idx;
    shifting = m_act && (m_pos < 2 * D * N);
    k   = m_pos / (2 * D);
    hi  = (m_pos % (2 * D)) >= D;
    idx = msb ? (N - 1 - k) : k;
    dat = shifting ? m_frm[idx[3:0]] : 1'b0;
    return {shifting && hi, dat, m_act && !shifting, m_act, m_dn};
  endfunction

  // Compare process plus serial capture bookkeeping.
  bit          go = 1'b0;
  int          frames = 0, busy_cyc = 0, lat_cyc = 0, rise_m = 0, rise_l = 0;
  logic [15:0] cap_m = '0, cap_l = '0;
  logic        pm_clk = 1'b0, pl_clk = 1'b0;
  logic [15:0] log_m[$];
  logic [15:0] log_l[$];

  initial forever begin
    @(negedge clk);
    if (go) begin
      chk("msb_outputs", {27'd0, m_clk, m_dat, m_lat, m_busy, m_done}, {27'd0, expect_out(1'b1)});
      chk("lsb_outputs", {27'd0, l_clk, l_dat, l_lat, l_busy, l_done}, {27'd0, expect_out(1'b0)});
      if (!rst_n) begin
        rise_m = 0; rise_l = 0;
      end
      if (m_busy) busy_cyc++;
      if (m_lat)  lat_cyc++;
      if (m_clk && !pm_clk) begin cap_m = {cap_m[14:0], m_dat}; rise_m++; end
      if (l_clk && !pl_clk) begin cap_l = {l_dat, cap_l[15:1]}; rise_l++; end
      if (m_done) begin
        chk("msb_rises_per_frame", rise_m, 16);
        log_m.push_back(cap_m); frames++; rise_m = 0;
      end
      if (l_done) begin
        chk("lsb_rises_per_frame", rise_l, 16);
        log_l.push_back(cap_l); rise_l = 0;
      end
      pm_clk = m_clk;
      pl_clk = l_clk;
    end
  end

  function automatic logic [15:0] log_at(input bit msb, input int i);
    if (msb) return (i < log_m.size()) ? log_m[i] : 16'hxxxx;
    else     return (i < log_l.size()) ? log_l[i] : 16'hxxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_force();
    force_upd = 1'b1; tick(1); force_upd = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int i;
    i = 0;
    while ((m_act || m_busy || m_pnd || (lp != m_snt)) && (i < budget)) begin
      tick(1); i++;
    end
    if (i >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=busy required=idle within %0d cycles", nm, budget);
    end
    tick(3);
  endtask

  task automatic wait_busy(input string nm, input int budget);
    int i;
    i = 0;
    while (!m_busy && (i < budget)) begin tick(1); i++; end
    if (i >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=idle required=busy within %0d cycles", nm, budget);
    end
  endtask

  int b_f, b_busy, b_lat, b_log;

  task automatic snap();
    b_f = frames; b_busy = busy_cyc; b_lat = lat_cyc; b_log = log_m.size();
  endtask

  initial begin
    tick(3);
    go = 1'b1;
    chk("reset_outputs", {22'd0, m_clk, m_dat, m_lat, m_busy, m_done,
                          l_clk, l_dat, l_lat, l_busy, l_done}, 32'd0);
    rst_n = 1'b1;

    // lp held at zero: no frame at all
    snap();
    tick(200);
    chk("idle_no_frame", frames - b_f, 0);
    chk("idle_no_busy", busy_cyc - b_busy, 0);

    // single bit, MSB first
    snap();
    lp = 16'h0001;
    wait_idle("s2", 300);
    chk("s2_frames", frames - b_f, 1);
    chk("s2_busy_cycles", busy_cyc - b_busy, 66);
    chk("s2_lat_cycles", lat_cyc - b_lat, 2);
    chk("s2_word", log_at(1'b1, b_log), 16'h0001);

    // pattern frame, both bit orders
    snap();
    lp = 16'hA5C3;
    wait_idle("s3", 300);
    chk("s3_lsb_word", log_at(1'b0, b_log), 16'hA5C3);
    chk("s3_msb_word", log_at(1'b1, b_log), 16'hA5C3);

    // mid-frame changes: last value wins, intermediate skipped
    snap();
    lp = 16'h0003;
    wait_busy("s4", 20);
    tick(10); lp = 16'h0007;
    tick(20); lp = 16'h000F;
    wait_idle("s4", 400);
    chk("s4_frames", frames - b_f, 2);
    chk("s4_first", log_at(1'b1, b_log), 16'h0003);
    chk("s4_second", log_at(1'b1, b_log + 1), 16'h000F);
    chk("s4_busy_back_to_back", busy_cyc - b_busy, 132);

    // forced refresh in idle
    snap();
    pulse_force();
    wait_idle("s5a", 300);
    chk("s5a_frames", frames - b_f, 1);
    chk("s5a_word", log_at(1'b1, b_log), 16'h000F);

    // three forces during busy collapse to one extra frame
    snap();
    pulse_force();
    wait_busy("s5b", 20);
    for (int i = 0; i < 3; i++) begin tick(7); pulse_force(); end
    wait_idle("s5b", 400);
    chk("s5b_frames", frames - b_f, 2);

    // reset in the 20th busy cycle
    snap();
    lp = 16'h0010;
    wait_busy("s6", 20);
    tick(19);
    #2 rst_n = 1'b0;
    #1 chk("s6_async_reset", {22'd0, m_clk, m_dat, m_lat, m_busy, m_done,
                              l_clk, l_dat, l_lat, l_busy, l_done}, 32'd0);
    tick(2);
    lp = 16'h8000;
    rst_n = 1'b1;
    wait_idle("s6", 300);
    chk("s6_frames", frames - b_f, 1);
    chk("s6_lat_cycles", lat_cyc - b_lat, 2);
    chk("s6_word", log_at(1'b1, b_log), 16'h8000);

    // randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: lp = 16'($urandom);
        1: pulse_force();
        2: lp = lp ^ (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      tick($urandom_range(1, 80));
    end
    wait_idle("rand", 1000);
    chk("rand_last_value_sent", log_at(1'b1, log_m.size() - 1), lp);
    chk("rand_lsb_matches", log_at(1'b0, log_l.size() - 1), lp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
